// File: rtl/bio_ram_pkg.sv
// Shared types for the BIO RAM write front end: default widths, FSM states, request layout.
// The optional write counter is enabled by defining BIO_RAM_WR_STATS_EN.
package bio_ram_pkg;

    localparam int BIO_RAM_ADDR_W = 10;
    localparam int BIO_RAM_DATA_W = 32;
    localparam int BIO_RAM_MASK_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } wr_state_e;

    typedef struct packed {
        logic [BIO_RAM_ADDR_W-1:0] addr;
        logic [BIO_RAM_DATA_W-1:0] data;
        logic [BIO_RAM_MASK_W-1:0] mask;
    } wr_req_t;

    // Bits per byte lane for a given word/mask split.
    function automatic int lane_bits(input int data_w, input int mask_w);
        return data_w / mask_w;
    endfunction

endpackage

// File: rtl/bio_ram_wr_ctrl_if.sv
// Host write-request channel (valid/ready with byte mask) into the BIO RAM write front end.
interface bio_ram_wr_ctrl_if
    import bio_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = BIO_RAM_ADDR_W,
    parameter int DATA_WIDTH = BIO_RAM_DATA_W,
    parameter int MASK_WIDTH = BIO_RAM_MASK_W
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic [MASK_WIDTH-1:0] req_mask;

    modport master (
        output req_valid, req_addr, req_data, req_mask,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_mask,
        output req_ready
    );

endinterface

// File: rtl/bio_ram_wr_fifo.sv
// Small synchronous request FIFO; pointers carry one extra wrap bit to tell full from empty.
module bio_ram_wr_fifo
    import bio_ram_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = wr_req_t
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     pop_data,
    output logic full,
    output logic empty
);
    localparam int PW = $clog2(DEPTH) + 1;

    T               mem [DEPTH];
    logic [PW-1:0]  wp, rp;
    logic           do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

    // Storage needs no reset: an entry is only visible once wp has passed it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wp[PW-2:0]] <= push_data;
    end

    assign pop_data = mem[rp[PW-2:0]];
    assign empty    = (wp == rp);
    assign full     = (wp[PW-1] != rp[PW-1]) && (wp[PW-2:0] == rp[PW-2:0]);

endmodule

// File: rtl/bio_ram_wr_ctrl.sv
// Sole driver of the BIO RAM write port: queues host writes and runs the zero-clear sweep.
// Defining BIO_RAM_WR_STATS_EN adds stats_clr / wr_count (host writes issued, saturating).
module bio_ram_wr_ctrl
    import bio_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = BIO_RAM_ADDR_W,
    parameter int DATA_WIDTH = BIO_RAM_DATA_W,
    parameter int MASK_WIDTH = BIO_RAM_MASK_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    bio_ram_wr_ctrl_if.slave      req_if,
    input  logic                  clear_req,
    output logic                  clear_busy,
    output logic                  idle,
    output logic                  wr_en,
    output logic [MASK_WIDTH-1:0] wr_mask,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data
`ifdef BIO_RAM_WR_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [31:0]           wr_count
`endif
);
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [MASK_WIDTH-1:0] mask;
    } req_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    req_t                  fifo_wr, fifo_rd;
    logic                  fifo_full, fifo_empty, push, pop;
    logic                  rdy_q;
    wr_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  clr_issue, host_issue;
    logic [ADDR_WIDTH-1:0] clr_wr_addr;

    // ---------------- host request buffer ----------------
    assign req_if.req_ready = rdy_q && !fifo_full;
    assign push             = req_if.req_valid && req_if.req_ready;
    assign fifo_wr          = '{addr: req_if.req_addr, data: req_if.req_data, mask: req_if.req_mask};

    bio_ram_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (req_t)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (fifo_wr),
        .pop       (pop),
        .pop_data  (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Keeps req_ready low while reset is held and for the release cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdy_q <= 1'b0;
        else          rdy_q <= 1'b1;
    end

    // ---------------- sequencer ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // A clear from IDLE issues address 0 on the request cycle so the sweep
    // occupies exactly 2**ADDR_WIDTH cycles of clear_busy.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        pop        = 1'b0;
        clr_issue  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    clr_issue  = 1'b1;
                    clr_addr_d = ADDR_WIDTH'(1);
                    state_d    = CLEAR;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                pop = !fifo_empty;
                if (clear_req) begin
                    clr_addr_d = '0;
                    state_d    = CLEAR;
                end else if (fifo_empty) begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                clr_issue = 1'b1;
                if (clr_addr_q == LAST_ADDR) state_d = fifo_empty ? IDLE : DRAIN;
                else                         clr_addr_d = clr_addr_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign host_issue  = pop && (fifo_rd.mask != '0);
    assign clr_wr_addr = (state_q == CLEAR) ? clr_addr_q : '0;

    // ---------------- registered RAM write port ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en      <= 1'b0;
            wr_mask    <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            clear_busy <= 1'b0;
        end else begin
            wr_en      <= clr_issue || host_issue;
            clear_busy <= clr_issue || (state_d == CLEAR);
            if (clr_issue) begin
                wr_addr <= clr_wr_addr;
                wr_data <= '0;
                wr_mask <= '1;
            end else if (host_issue) begin
                wr_addr <= fifo_rd.addr;
                wr_data <= fifo_rd.data;
                wr_mask <= fifo_rd.mask;
            end
        end
    end

    assign idle = !clear_busy && fifo_empty && !wr_en;

`ifdef BIO_RAM_WR_STATS_EN
    // stats_clr takes priority, so an increment in the same cycle is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                               wr_count <= '0;
        else if (stats_clr)                         wr_count <= '0;
        else if (host_issue && (wr_count != '1))    wr_count <= wr_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_bio_ram_wr_ctrl.sv
// Directed + randomized bench for bio_ram_wr_ctrl; expected writes come from an ordered
// acceptance queue and the clear-sweep rules, compared against a negedge write monitor.
module tb_bio_ram_wr_ctrl;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int FD = 4;
    localparam int NWORDS = 1 << AW;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear_req;
    logic          clear_busy, idle, wr_en;
    logic [MW-1:0] wr_mask;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
`ifdef BIO_RAM_WR_STATS_EN
    logic          stats_clr;
    logic [31:0]   wr_count;
`endif

    bio_ram_wr_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) rif ();

    bio_ram_wr_ctrl #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .MASK_WIDTH (MW), .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_if     (rif),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .idle       (idle),
        .wr_en      (wr_en),
        .wr_mask    (wr_mask),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
`ifdef BIO_RAM_WR_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .wr_count   (wr_count)
`endif
    );

    always #5 clk = ~clk;

    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;
    int  host_total = 0;
    wr_t obs_q[$];
    wr_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n && wr_en) obs_q.push_back('{cyc, wr_addr, wr_data, wr_mask});
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Holds the request until the DUT takes it; accepted non-zero-mask requests join the model.
    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        logic acc;
        acc = 1'b0;
        rif.req_valid = 1'b1;
        rif.req_addr  = a;
        rif.req_data  = d;
        rif.req_mask  = m;
        for (int k = 0; k < 100; k++) begin
            acc = rif.req_ready;
            tick();
            if (acc) break;
        end
        rif.req_valid = 1'b0;
        check("send_accept", 64'(acc), 64'd1);
        if (acc && m != '0) begin
            exp_q.push_back('{0, a, d, m});
            host_total++;
        end
    endtask

    task automatic exp_clear();
        for (int i = 0; i < NWORDS; i++) exp_q.push_back('{0, AW'(i), '0, '1});
    endtask

    task automatic wait_idle(input string tag);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (idle) begin ok = 1'b1; break; end
            tick();
        end
        check(tag, 64'(ok), 64'd1);
        tick();
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check({tag, "_write"}, 64'({obs_q[i].addr, obs_q[i].data, obs_q[i].mask}),
                                   64'({exp_q[i].addr, exp_q[i].data, exp_q[i].mask}));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [19:0] busy_v, en_v;
        logic        hit;
        reset_n       = 1'b0;
        clear_req     = 1'b0;
        rif.req_valid = 1'b0;
        rif.req_addr  = '0;
        rif.req_data  = '0;
        rif.req_mask  = '0;
`ifdef BIO_RAM_WR_STATS_EN
        stats_clr     = 1'b0;
`endif
        repeat (3) tick();

        // Reset state
        check("rst_ready", 64'(rif.req_ready), 64'd0);
        check("rst_busy",  64'(clear_busy), 64'd0);
        check("rst_idle",  64'(idle), 64'd1);
        check("rst_wr",    64'({wr_en, wr_mask, wr_addr, wr_data}), 64'd0);
`ifdef BIO_RAM_WR_STATS_EN
        check("rst_count", 64'(wr_count), 64'd0);
`endif
        reset_n = 1'b1;
        tick();
        check("post_rst_ready", 64'(rif.req_ready), 64'd1);
        check("pre_idle", 64'(idle), 64'd1);

        // Single write latency: accepted at N, wr_en at N+2, idle at N+3
        send(4'h5, 32'hDEADBEEF, 4'hF);
        check("lat_n1_wr_en", 64'(wr_en), 64'd0);
        check("lat_n1_idle", 64'(idle), 64'd0);
        tick();
        check("lat_n2_wr_en", 64'(wr_en), 64'd1);
        check("lat_n2_fields", 64'({wr_addr, wr_data, wr_mask}), 64'({4'h5, 32'hDEADBEEF, 4'hF}));
        tick();
        check("lat_n3_idle", 64'(idle), 64'd1);
        check("lat_n3_wr_en", 64'(wr_en), 64'd0);
        compare_writes("single");

        // Six back-to-back requests drain one per cycle in order
        for (int i = 0; i < 6; i++) send(AW'(i + 8), $urandom, 4'hF);
        wait_idle("b2b_idle");
        if (obs_q.size() == 6)
            for (int i = 1; i < 6; i++) check("b2b_spacing", 64'(obs_q[i].cyc - obs_q[0].cyc), 64'(i));
        compare_writes("b2b");

        // Zero-mask entry is dropped but costs a cycle
        send(4'h1, 32'h1111_1111, 4'h3);
        send(4'h2, 32'h2222_2222, 4'h0);
        send(4'h3, 32'h3333_3333, 4'h3);
        wait_idle("mask0_idle");
        if (obs_q.size() == 2) check("mask0_gap", 64'(obs_q[1].cyc - obs_q[0].cyc), 64'd2);
        compare_writes("mask0");

        // Clear sweep: 16 writes and clear_busy covering exactly those cycles
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            busy_v[i] = clear_busy;
            en_v[i]   = wr_en;
            tick();
        end
        check("clr_busy_window", 64'(busy_v), 64'h0FFFF);
        check("clr_wr_en_window", 64'(en_v), 64'h0FFFF);
        exp_clear();
        wait_idle("clr_idle");
        compare_writes("clear");

        // Requests during a sweep fill the FIFO, wait for the sweep, then issue in order;
        // a second clear_req mid-sweep does not restart it
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        exp_clear();
        for (int i = 0; i < FD; i++) send(AW'(i), $urandom, 4'(i + 1));
        check("full_ready_low", 64'(rif.req_ready), 64'd0);
        check("full_busy", 64'(clear_busy), 64'd1);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        send(4'hA, $urandom, 4'hC);
        send(4'hB, $urandom, 4'h9);
        wait_idle("sweep_q_idle");
        compare_writes("sweep_q");

        // Randomized traffic with gaps and dropped zero-mask entries
        for (int i = 0; i < 40; i++) begin
            send(AW'($urandom_range(0, NWORDS - 1)), $urandom,
                 ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15)));
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_idle("rand_idle");
        compare_writes("rand");
`ifdef BIO_RAM_WR_STATS_EN
        check("stats_count", 64'(wr_count), 64'(host_total));
`endif

        // Asynchronous reset at clear address 7 with entries queued
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        send(4'h3, 32'hA5A5_A5A5, 4'hF);
        send(4'h4, 32'h5A5A_5A5A, 4'hF);
        hit = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (wr_en && wr_addr == 4'd7) begin hit = 1'b1; break; end
            tick();
        end
        check("rst_reach_addr7", 64'(hit), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_wr_en", 64'(wr_en), 64'd0);
        check("mid_rst_busy", 64'(clear_busy), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("rel_idle", 64'(idle), 64'd1);
        check("rel_ready", 64'(rif.req_ready), 64'd1);
        obs_q.delete();
        exp_q.delete();
        repeat (6) tick();
        check("rel_no_writes", 64'(obs_q.size()), 64'd0);
        check("rel_idle_hold", 64'(idle), 64'd1);
`ifdef BIO_RAM_WR_STATS_EN
        check("rel_count", 64'(wr_count), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
